weight_stream_parser: RTL and testbench

- Downstream consumer of the quantized model byte stream produced by the weight-file loading stage.
- Parses the 8-byte layer header: num_rows (u32 LE), then num_cols (u32 LE).
- Validates the dimensions, then forwards num_rows*num_cols weight bytes with row/col indices over a valid/ready handshake to the layer weight buffer / MAC feeder.
- Handles one layer per start pulse.

---
 rtl/model_pkg.sv | 34 +++
 rtl/weight_stream_parser_rc_counter.sv | 40 ++++
 rtl/weight_stream_parser.sv | 167 ++++++++++++++++
 tb/tb_weight_stream_parser.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/model_pkg.sv
// Shared definitions for the model-loading pipeline: parser state encoding,
// header-check error codes and the dimension defaults used by the loading
// stage, the weight stream parser and the MAC feeder.
package model_pkg;

  localparam int WEIGHT_WIDTH_DEF = 8;
  localparam int MAX_NEURONS_DEF  = 1024;
  localparam int HDR_BYTES        = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_CHECK  = 3'd2,
    ST_STREAM = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } parser_state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_ZERO = 2'd1;
  localparam logic [1:0] ERR_ROWS = 2'd2;
  localparam logic [1:0] ERR_COLS = 2'd3;

  // Header dimension check; zero dimension outranks rows, rows outrank cols.
  function automatic logic [1:0] check_dims(input logic [31:0] rows,
                                            input logic [31:0] cols,
                                            input logic [31:0] max_n);
    if (rows == 32'd0 || cols == 32'd0) return ERR_ZERO;
    if (rows > max_n)                    return ERR_ROWS;
    if (cols > max_n)                    return ERR_COLS;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/weight_stream_parser_rc_counter.sv
// Row/column index pair for the weight stream. Column wraps at
// last_col_idx and carries into the row; flags mark the last column and
// the final element of the layer for the index currently presented.
module rc_counter #(
  parameter int IDX_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [IDX_WIDTH-1:0] last_col_idx,
  input  logic [IDX_WIDTH-1:0] last_row_idx,
  output logic [IDX_WIDTH-1:0] row,
  output logic [IDX_WIDTH-1:0] col,
  output logic                 last_col,
  output logic                 last
);

  assign last_col = (col == last_col_idx);
  assign last     = last_col && (row == last_row_idx);

  // Advance the index pair by one element per enable, wrapping columns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (enable) begin
      if (last_col) begin
        col <= '0;
        row <= row + IDX_WIDTH'(1);
      end else begin
        col <= col + IDX_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/weight_stream_parser.sv
// Parses one layer of the quantized model byte stream: an 8-byte header
// (rows, cols as little-endian u32), a dimension check, then rows*cols
// weight bytes forwarded with row/col indices through a single output
// register on a valid/ready handshake.
module weight_stream_parser
  import model_pkg::*;
#(
  parameter int WEIGHT_WIDTH = WEIGHT_WIDTH_DEF,
  parameter int MAX_NEURONS  = MAX_NEURONS_DEF,
  parameter int IDX_WIDTH    = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [WEIGHT_WIDTH-1:0] in_data,
  output logic                    in_ready,
  output logic [31:0]             num_rows,
  output logic [31:0]             num_cols,
  output logic                    hdr_valid,
  output logic                    w_valid,
  input  logic                    w_ready,
  output logic [WEIGHT_WIDTH-1:0] w_data,
  output logic [IDX_WIDTH-1:0]    w_row,
  output logic [IDX_WIDTH-1:0]    w_col,
  output logic                    w_last_col,
  output logic                    w_last,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [1:0]              err_code
);

  parser_state_t        state, state_nxt;
  logic [2:0]           byte_cnt;
  logic                 last_taken;
  logic                 in_hs;
  logic                 out_hs;
  logic                 start_acc;
  logic [1:0]           chk_code;
  logic [IDX_WIDTH-1:0] cnt_row, cnt_col;
  logic [IDX_WIDTH-1:0] last_col_idx, last_row_idx;
  logic                 cnt_last_col, cnt_last;

  // Only the low index bits matter; the header check has already bounded
  // both dimensions to 1..MAX_NEURONS, so MAX_NEURONS itself wraps to 0
  // and the decrement still yields the all-ones last index.
  assign last_col_idx = num_cols[IDX_WIDTH-1:0] - IDX_WIDTH'(1);
  assign last_row_idx = num_rows[IDX_WIDTH-1:0] - IDX_WIDTH'(1);

  assign chk_code  = check_dims(num_rows, num_cols, 32'(MAX_NEURONS));
  assign start_acc = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = w_valid && w_ready;
  assign busy      = (state == ST_HDR) || (state == ST_CHECK) || (state == ST_STREAM);
  assign done      = (state == ST_STREAM) && out_hs && w_last;

  rc_counter #(
    .IDX_WIDTH (IDX_WIDTH)
  ) u_rc (
    .clk          (clk),
    .rst          (rst),
    .clear        (start_acc),
    .enable       ((state == ST_STREAM) && in_hs),
    .last_col_idx (last_col_idx),
    .last_row_idx (last_row_idx),
    .row          (cnt_row),
    .col          (cnt_col),
    .last_col     (cnt_last_col),
    .last         (cnt_last)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and input-side flow control.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) state_nxt = ST_HDR;
      end
      ST_HDR: begin
        in_ready = 1'b1;
        if (in_valid && byte_cnt == 3'(HDR_BYTES - 1)) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        state_nxt = (chk_code == ERR_NONE) ? ST_STREAM : ST_ERR;
      end
      ST_STREAM: begin
        // Once the final byte is held, stop taking input until it drains.
        in_ready = !last_taken && (!w_valid || w_ready);
        if (out_hs && w_last) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Header capture, dimension check result and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt  <= '0;
      num_rows  <= '0;
      num_cols  <= '0;
      hdr_valid <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else if (start_acc) begin
      byte_cnt  <= '0;
      hdr_valid <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      case (state)
        ST_HDR: begin
          if (in_hs) begin
            if (!byte_cnt[2]) num_rows[{byte_cnt[1:0], 3'b000} +: 8] <= in_data[7:0];
            else              num_cols[{byte_cnt[1:0], 3'b000} +: 8] <= in_data[7:0];
            byte_cnt <= byte_cnt + 3'd1;
          end
        end
        ST_CHECK: begin
          if (chk_code != ERR_NONE) begin
            err      <= 1'b1;
            err_code <= chk_code;
          end else begin
            hdr_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output register: loads on an input handshake, empties on an output
  // handshake, and holds everything stable while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_valid    <= 1'b0;
      w_data     <= '0;
      w_row      <= '0;
      w_col      <= '0;
      w_last_col <= 1'b0;
      w_last     <= 1'b0;
      last_taken <= 1'b0;
    end else if (start_acc) begin
      last_taken <= 1'b0;
    end else if (state == ST_STREAM) begin
      if (in_hs) begin
        w_valid    <= 1'b1;
        w_data     <= in_data;
        w_row      <= cnt_row;
        w_col      <= cnt_col;
        w_last_col <= cnt_last_col;
        w_last     <= cnt_last;
        last_taken <= cnt_last;
      end else if (out_hs) begin
        w_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_weight_stream_parser.sv
// Bench for weight_stream_parser: randomized layers with random input gaps
// and output back-pressure, checked every cycle against a reference model
// of the expected weight sequence, plus header error cases and reset abort.
module tb_weight_stream_parser;

  localparam int WW   = 8;
  localparam int MAXN = 1024;
  localparam int IW   = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [WW-1:0] in_data = '0;
  logic          in_ready;
  logic [31:0]   num_rows, num_cols;
  logic          hdr_valid;
  logic          w_valid;
  logic          w_ready = 1'b1;
  logic [WW-1:0] w_data;
  logic [IW-1:0] w_row, w_col;
  logic          w_last_col, w_last;
  logic          busy, done, err;
  logic [1:0]    err_code;

  weight_stream_parser #(
    .WEIGHT_WIDTH (WW),
    .MAX_NEURONS  (MAXN),
    .IDX_WIDTH    (IW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .num_rows   (num_rows),
    .num_cols   (num_cols),
    .hdr_valid  (hdr_valid),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_data     (w_data),
    .w_row      (w_row),
    .w_col      (w_col),
    .w_last_col (w_last_col),
    .w_last     (w_last),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model of the current layer.
  int         m_rows, m_cols, total, oi;
  logic [7:0] pay [0:2047];
  bit         mon_en = 1'b0;
  bit         prev_stall = 1'b0;
  logic [WW+2*IW+1:0] prev_bus;
  logic       exp_done;
  int         done_cnt, done_cyc, last_in_cyc, first_pay_cyc;
  logic [7:0]    obs_data [0:7];
  logic [IW-1:0] obs_row  [0:7];
  logic [IW-1:0] obs_col  [0:7];
  logic          obs_lc   [0:7];
  logic          obs_l    [0:7];
  int         rdy_mode = 0;
  int         rdy_ph   = 0;
  bit         gaps     = 1'b0;
  bit [3:0]   rdy_pat  = 4'b1001;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_code(input int unsigned r, input int unsigned c);
    if (r == 0 || c == 0) return 2'd1;
    if (r > MAXN)         return 2'd2;
    if (c > MAXN)         return 2'd3;
    return 2'd0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer back-pressure generator.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: w_ready = 1'b1;
      1: begin w_ready = rdy_pat[rdy_ph]; rdy_ph = (rdy_ph + 1) % 4; end
      default: w_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Compare process: checks the output side against the model every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall) begin
        check("stall_valid_hold", 64'(w_valid), 64'd1);
        check("stall_bus_hold", 64'({w_data, w_row, w_col, w_last_col, w_last}), 64'(prev_bus));
      end
      exp_done = 1'b0;
      if (w_valid && oi >= total) begin
        check("w_valid_unexpected", 64'(w_valid), 64'd0);
      end else if (w_valid && w_ready) begin
        check("w_data", 64'(w_data), 64'(pay[oi]));
        check("w_row", 64'(w_row), 64'(oi / m_cols));
        check("w_col", 64'(w_col), 64'(oi % m_cols));
        check("w_last_col", 64'(w_last_col), 64'((oi % m_cols) == m_cols - 1));
        check("w_last", 64'(w_last), 64'(oi == total - 1));
        if (oi < 8) begin
          obs_data[oi] = w_data;
          obs_row[oi]  = w_row;
          obs_col[oi]  = w_col;
          obs_lc[oi]   = w_last_col;
          obs_l[oi]    = w_last;
        end
        exp_done = (oi == total - 1);
        oi++;
      end
      check("done", 64'(done), 64'(exp_done));
      if (done) begin done_cnt++; done_cyc = cyc; end
      prev_stall = w_valid && !w_ready;
      prev_bus   = {w_data, w_row, w_col, w_last_col, w_last};
    end else begin
      prev_stall = 1'b0;
    end
  end

  // All tasks below enter and leave one time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int  n;
    bit  ok;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    n  = 0;
    ok = 1'b0;
    while (n < 500) begin
      @(negedge clk);
      if (in_ready) begin
        last_in_cyc = cyc;
        ok = 1'b1;
        break;
      end
      n++;
    end
    if (!ok) check("in_ready_timeout", 64'd0, 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_header(input logic [31:0] r, input logic [31:0] c);
    for (int k = 0; k < 8; k++) begin
      if (k < 4) send_byte(r[8*k +: 8]);
      else       send_byte(c[8*(k-4) +: 8]);
    end
  endtask

  // fill < 0: random bytes, otherwise fill, fill+1, ...
  task automatic setup_layer(input int r, input int c, input int mode, input bit gp, input int fill);
    m_rows   = r;
    m_cols   = c;
    total    = r * c;
    oi       = 0;
    done_cnt = 0;
    for (int i = 0; i < total; i++)
      pay[i] = (fill < 0) ? 8'($urandom_range(0, 255)) : 8'(fill + i);
    rdy_mode = mode;
    rdy_ph   = 0;
    gaps     = gp;
    mon_en   = 1'b1;
  endtask

  task automatic run_stream(input int r, input int c, input int mode, input bit gp, input int fill);
    int n;
    setup_layer(r, c, mode, gp, fill);
    pulse_start();
    send_header(32'(r), 32'(c));
    for (int i = 0; i < total; i++) begin
      send_byte(pay[i]);
      if (i == 0) first_pay_cyc = last_in_cyc;
    end
    n = 0;
    while (oi < total && n < 5000) begin tick(); n++; end
    if (oi < total) check("stream_timeout", 64'(oi), 64'(total));
    tick();
    @(negedge clk);
    check("num_rows", 64'(num_rows), 64'(r));
    check("num_cols", 64'(num_cols), 64'(c));
    check("hdr_valid_done", 64'(hdr_valid), 64'd1);
    check("err_clear", 64'(err), 64'd0);
    check("busy_done", 64'(busy), 64'd0);
    check("w_valid_after", 64'(w_valid), 64'd0);
    check("in_ready_done", 64'(in_ready), 64'd0);
    check("done_count", 64'(done_cnt), 64'd1);
    tick();
  endtask

  task automatic run_err(input int unsigned r, input int unsigned c, input logic [1:0] lit_code);
    setup_layer(0, 1, 0, 1'b0, 0);
    pulse_start();
    send_header(32'(r), 32'(c));
    in_valid = 1'b1;
    in_data  = 8'h5A;
    tick();
    tick();
    @(negedge clk);
    check("err_flag", 64'(err), 64'd1);
    check("err_code_model", 64'(err_code), 64'(exp_code(r, c)));
    check("err_code_literal", 64'(err_code), 64'(lit_code));
    check("err_in_ready", 64'(in_ready), 64'd0);
    check("err_busy", 64'(busy), 64'd0);
    check("err_hdr_valid", 64'(hdr_valid), 64'd0);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hdr"}, {num_rows, num_cols}, 64'd0);
    check({tag, "_ctl"}, 64'({in_ready, hdr_valid, w_valid, w_data, w_row, w_col,
                              w_last_col, w_last, busy, done, err, err_code}), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_state");
    tick();
    rst = 1'b0;
    tick();

    // Directed 2x3 layer, bytes 0x10..0x15, consumer always ready.
    run_stream(2, 3, 0, 1'b0, 8'h10);
    check("lit_rows", 64'(num_rows), 64'd2);
    check("lit_cols", 64'(num_cols), 64'd3);
    check("lit_data5", 64'(obs_data[5]), 64'h15);
    check("lit_rc3", 64'({obs_row[3], obs_col[3]}), 64'({10'd1, 10'd0}));
    check("lit_rc2", 64'({obs_row[2], obs_col[2]}), 64'({10'd0, 10'd2}));
    check("lit_lastcol", 64'({obs_lc[0], obs_lc[1], obs_lc[2], obs_lc[3], obs_lc[4], obs_lc[5]}), 64'b001001);
    check("lit_last", 64'({obs_l[0], obs_l[1], obs_l[2], obs_l[3], obs_l[4], obs_l[5]}), 64'b000001);
    check("no_bubble", 64'(last_in_cyc - first_pay_cyc), 64'd5);
    check("done_latency", 64'(done_cyc - last_in_cyc), 64'd1);

    // Same layer with the consumer stalling in a 1,0,0,1 pattern.
    run_stream(2, 3, 1, 1'b0, 8'h10);
    check("toggle_data3", 64'(obs_data[3]), 64'h13);
    check("toggle_count", 64'(oi), 64'd6);

    // Header errors, including priority between the codes.
    run_err(0, 5, 2'd1);
    run_err(1025, 0, 2'd1);
    run_err(1025, 4, 2'd2);
    run_err(4, 2000, 2'd3);
    run_err(1024, 1025, 2'd3);

    // Randomized small layers with input gaps and random back-pressure.
    for (int t = 0; t < 6; t++)
      run_stream($urandom_range(1, 5), $urandom_range(1, 6), 2, 1'b1, -1);

    // Largest legal dimensions exercise the full index width.
    run_stream(1024, 1, 2, 1'b0, -1);
    run_stream(1, 1024, 0, 1'b0, -1);

    // Reset in the middle of a layer aborts it.
    setup_layer(2, 3, 0, 1'b0, 8'h10);
    pulse_start();
    send_header(32'd2, 32'd3);
    for (int i = 0; i < 6; i++) begin
      send_byte(pay[i]);
      if (oi >= 3) break;
    end
    check("pre_reset_progress", 64'(oi), 64'd3);
    mon_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");
    tick();

    // Fresh 1x1 layer after the abort.
    run_stream(1, 1, 0, 1'b0, 8'hAA);
    check("one_data", 64'(obs_data[0]), 64'hAA);
    check("one_rc", 64'({obs_row[0], obs_col[0]}), 64'd0);
    check("one_last", 64'({obs_lc[0], obs_l[0]}), 64'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
